// File: rtl/pe_ctrl_pkg.sv
// Shared PE_control definitions: sequencer FSM encoding, phase count and default widths.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pe_state_e;

  localparam int PHASES    = 4;
  localparam int DEF_DIM_W = 4;
  localparam int DEF_CNT_W = 10;

endpackage

// File: rtl/pe_idx_walker.sv
// Cascaded wrap counters phase -> q -> p -> s; one advance per adv_i, cleared by clr_i.
// Zero latency: indices move at the edge that ends an advancing cycle.
module pe_idx_walker
  import pe_ctrl_pkg::*;
#(
  parameter int DIM_W = DEF_DIM_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIM_W-1:0] lim_q_i,
  input  logic [DIM_W-1:0] lim_p_i,
  output logic [1:0]       idx_phase_o,
  output logic [DIM_W-1:0] idx_q_o,
  output logic [DIM_W-1:0] idx_p_o,
  output logic [DIM_W-1:0] idx_s_o
);

  localparam logic [1:0] PH_LAST = 2'(PHASES - 1);

  logic [1:0]       phase_q, phase_d;
  logic [DIM_W-1:0] q_q, q_d, p_q, p_d, s_q, s_d;
  logic             ph_wrap, q_wrap, p_wrap;

  assign ph_wrap = (phase_q == PH_LAST);
  assign q_wrap  = (q_q == lim_q_i - DIM_W'(1));
  assign p_wrap  = (p_q == lim_p_i - DIM_W'(1));

  // s never needs a wrap: the sequencer stops advancing on the final step.
  always_comb begin
    phase_d = phase_q;
    q_d     = q_q;
    p_d     = p_q;
    s_d     = s_q;
    if (clr_i) begin
      phase_d = '0;
      q_d     = '0;
      p_d     = '0;
      s_d     = '0;
    end else if (adv_i) begin
      phase_d = ph_wrap ? '0 : phase_q + 2'd1;
      if (ph_wrap) begin
        q_d = q_wrap ? '0 : q_q + DIM_W'(1);
        if (q_wrap) begin
          p_d = p_wrap ? '0 : p_q + DIM_W'(1);
          if (p_wrap) begin
            s_d = s_q + DIM_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
      q_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
    end else begin
      phase_q <= phase_d;
      q_q     <= q_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  assign idx_phase_o = phase_q;
  assign idx_q_o     = q_q;
  assign idx_p_o     = p_q;
  assign idx_s_o     = s_q;

endmodule

// File: rtl/pe_cycle_budget.sv
// Down-counting work sequencer: budget 4*S*P*Q, one step per cycle, done at N+2+total.
// Stall holds progress only when PE_CYCLE_BUDGET_STALL_EN is defined; otherwise stall is inert.
module pe_cycle_budget
  import pe_ctrl_pkg::*;
#(
  parameter int DIM_W = DEF_DIM_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [DIM_W-1:0] dim_s,
  input  logic [DIM_W-1:0] dim_p,
  input  logic [DIM_W-1:0] dim_q,
  input  logic             stall,
  output logic             busy,
  output logic             step,
  output logic [1:0]       idx_phase,
  output logic [DIM_W-1:0] idx_q,
  output logic [DIM_W-1:0] idx_p,
  output logic [DIM_W-1:0] idx_s,
  output logic [CNT_W-1:0] remaining,
  output logic             psum_last,
  output logic             done,
  output logic             err_ovf
);

  // Full product width, so an oversized job can never alias to a small budget.
  localparam int                 TOT_W      = 3 * DIM_W + 2;
  localparam logic [TOT_W-1:0]   MAX_BUDGET = TOT_W'((1 << CNT_W) - 1);

  pe_state_e        state_q, state_d;
  logic [DIM_W-1:0] s_q, s_d, p_q, p_d, q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [TOT_W-1:0] total;
  logic             stall_hold, run, last, adv, clr_idx;

`ifdef PE_CYCLE_BUDGET_STALL_EN
  assign stall_hold = stall;
`else
  assign stall_hold = stall & 1'b0;
`endif

  assign total = TOT_W'(PHASES) * TOT_W'(s_q) * TOT_W'(p_q) * TOT_W'(q_q);
  assign run   = (state_q == RUN);
  assign step  = run & ~stall_hold;
  assign last  = (rem_q == '0);
  assign adv   = step & ~last;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    s_d     = s_q;
    p_d     = p_q;
    q_d     = q_q;
    clr_idx = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = dim_s;
          p_d     = dim_p;
          q_d     = dim_q;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        clr_idx = 1'b1;
        if (total == '0) begin
          rem_d   = '0;
          state_d = DONE;
        end else if (total > MAX_BUDGET) begin
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = CNT_W'(total - TOT_W'(1));
          state_d = RUN;
        end
      end
      RUN: begin
        if (step) begin
          if (last) state_d = DONE;
          else      rem_d   = rem_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
      s_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      s_q     <= s_d;
      p_q     <= p_d;
      q_q     <= q_d;
    end
  end

  pe_idx_walker #(.DIM_W(DIM_W)) u_walker (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (clr_idx),
    .adv_i       (adv),
    .lim_q_i     (q_q),
    .lim_p_i     (p_q),
    .idx_phase_o (idx_phase),
    .idx_q_o     (idx_q),
    .idx_p_o     (idx_p),
    .idx_s_o     (idx_s)
  );

  assign busy      = (state_q == LOAD) | run;
  assign psum_last = run & last;
  assign done      = (state_q == DONE);
  assign remaining = rem_q;
  assign err_ovf   = err_q;

endmodule
